// File: rtl/mips_defs_pkg.sv
// Shared constants for the multi-cycle MIPS datapath: instruction opcodes,
// ALU operation codes (also used by the ALU) and control FSM state encodings.
package mips_defs;

    // Instruction opcodes, IR[31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALU operation select
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control FSM state encodings; codes 13..15 are unused
    localparam logic [3:0] S_RST     = 4'd0;
    localparam logic [3:0] S_FETCH   = 4'd1;
    localparam logic [3:0] S_DECODE  = 4'd2;
    localparam logic [3:0] S_MEMADR  = 4'd3;
    localparam logic [3:0] S_MEMRD   = 4'd4;
    localparam logic [3:0] S_MEMWB   = 4'd5;
    localparam logic [3:0] S_MEMWR   = 4'd6;
    localparam logic [3:0] S_EXEC    = 4'd7;
    localparam logic [3:0] S_RTYPEWB = 4'd8;
    localparam logic [3:0] S_BRANCH  = 4'd9;
    localparam logic [3:0] S_JUMP    = 4'd10;
    localparam logic [3:0] S_ADDI_EX = 4'd11;
    localparam logic [3:0] S_ADDI_WB = 4'd12;

    // True for every opcode the controller knows how to sequence
    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ)   || (op == OP_J)  || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM. Sequences fetch/decode/execute/memory/
// write-back, waits on mem_ready for every memory access, and drives the
// ALU operation, operand muxes and all datapath enables.
module mc_ctrl
    import mips_defs::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] ALUop,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSource,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_reg;
    logic [3:0] state_next;
    logic       pc_write;
    logic       pc_write_cond;

    assign state = state_reg;

    // State register; reset is asynchronous so outputs drop without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; memory states hold until the handshake completes
    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_RST:     state_next = S_FETCH;
            S_FETCH:   state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_FETCH;
                endcase
            end
            S_MEMADR:  state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_next = S_FETCH;
            S_MEMWR:   state_next = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_next = S_RTYPEWB;
            S_RTYPEWB: state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
            S_ADDI_EX: state_next = S_ADDI_WB;
            S_ADDI_WB: state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    // Output decode: Moore from state, with handshake/zero qualifiers folded in.
    // rst forces everything low so no write enable can appear during reset.
    always_comb begin
        ALUop         = ALU_ADD;
        ALUSrcA       = 1'b0;
        ALUSrcB       = SRCB_REG;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        RegWrite      = 1'b0;
        PCSource      = PCSRC_ALU;
        instr_done    = 1'b0;
        illegal       = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        if (!rst) begin
            case (state_reg)
                S_FETCH: begin
                    MemRead  = 1'b1;
                    ALUSrcB  = SRCB_FOUR;
                    IRWrite  = mem_ready;
                    pc_write = mem_ready;
                end
                S_DECODE: begin
                    ALUSrcB = SRCB_IMMSH;
                    if (!op_supported(op)) begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite   = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEMWR: begin
                    MemWrite   = 1'b1;
                    IorD       = 1'b1;
                    instr_done = mem_ready;
                end
                S_EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUop   = ALU_FUNC;
                end
                S_RTYPEWB: begin
                    RegWrite   = 1'b1;
                    RegDst     = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA       = 1'b1;
                    ALUop         = ALU_SUB;
                    pc_write_cond = 1'b1;
                    PCSource      = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    PCSource   = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                S_ADDI_EX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = SRCB_IMM;
                end
                S_ADDI_WB: begin
                    RegWrite   = 1'b1;
                    instr_done = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Branch enable follows zero combinationally within S_BRANCH
    assign pc_en = pc_write | (pc_write_cond & zero);

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: a per-cycle vector table of inputs and expected
// state/outputs, plus a hand sequence for asynchronous reset during a read.
module tb_mc_ctrl;
    import mips_defs::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUop;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
    logic [1:0] PCSource;
    logic       pc_en, instr_done, illegal;
    logic [3:0] state;

    int tests  = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
        .ALUop(ALUop), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .PCSource(PCSource), .pc_en(pc_en), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    // Observed outputs packed in a fixed order:
    // ALUop, SrcA, SrcB, IorD, MemRd, MemWr, IRW, RegDst, M2R, RegW, PCSrc, pc_en, done, illegal
    logic [16:0] obs;
    assign obs = {ALUop, ALUSrcA, ALUSrcB, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemtoReg, RegWrite, PCSource, pc_en, instr_done, illegal};

    localparam logic [16:0] O_FETCH_GO  = 17'b00_0_01_0_1_0_1_0_0_0_00_1_0_0;
    localparam logic [16:0] O_FETCH_W   = 17'b00_0_01_0_1_0_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_DECODE    = 17'b00_0_11_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_DECODE_IL = 17'b00_0_11_0_0_0_0_0_0_0_00_0_1_1;
    localparam logic [16:0] O_EXEC      = 17'b10_1_00_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_RTWB      = 17'b00_0_00_0_0_0_0_1_0_1_00_0_1_0;
    localparam logic [16:0] O_MEMADR    = 17'b00_1_10_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_MEMRD     = 17'b00_0_00_1_1_0_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_MEMWB     = 17'b00_0_00_0_0_0_0_0_1_1_00_0_1_0;
    localparam logic [16:0] O_MEMWR_W   = 17'b00_0_00_1_0_1_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_MEMWR_GO  = 17'b00_0_00_1_0_1_0_0_0_0_00_0_1_0;
    localparam logic [16:0] O_BR_TAKEN  = 17'b01_1_00_0_0_0_0_0_0_0_01_1_1_0;
    localparam logic [16:0] O_BR_NOT    = 17'b01_1_00_0_0_0_0_0_0_0_01_0_1_0;
    localparam logic [16:0] O_JUMP      = 17'b00_0_00_0_0_0_0_0_0_0_10_1_1_0;
    localparam logic [16:0] O_ADDI_EX   = 17'b00_1_10_0_0_0_0_0_0_0_00_0_0_0;
    localparam logic [16:0] O_ADDI_WB   = 17'b00_0_00_0_0_0_0_0_0_1_00_0_1_0;

    typedef struct packed {
        logic [5:0]  op;
        logic        zero;
        logic        mem_ready;
        logic [3:0]  st;
        logic [16:0] outs;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic [5:0] o, input logic z, input logic mr,
                                input logic [3:0] s, input logic [16:0] e);
        vec_t v;
        v.op = o; v.zero = z; v.mem_ready = mr; v.st = s; v.outs = e;
        return v;
    endfunction

    task automatic check_state(input string name, input logic [3:0] exp);
        tests++;
        if (state !== exp) begin
            errors++;
            $display("FAIL %s: state got %0d expected %0d", name, state, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [16:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: outputs got %b expected %b", name, obs, exp);
        end
    endtask

    initial begin
        // R-type, no wait states: 4 cycles
        vecs.push_back(mk(6'b000000, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b000000, 1'b0, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b000000, 1'b0, 1'b1, S_EXEC,    O_EXEC));
        vecs.push_back(mk(6'b000000, 1'b1, 1'b1, S_RTYPEWB, O_RTWB));
        // lw with three read wait states: 8 cycles
        vecs.push_back(mk(6'b100011, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b1, S_MEMADR,  O_MEMADR));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, S_MEMRD,   O_MEMRD));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, S_MEMRD,   O_MEMRD));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, S_MEMRD,   O_MEMRD));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b1, S_MEMRD,   O_MEMRD));
        vecs.push_back(mk(6'b100011, 1'b0, 1'b0, S_MEMWB,   O_MEMWB));
        // sw with one fetch wait and one write wait
        vecs.push_back(mk(6'b101011, 1'b0, 1'b0, S_FETCH,   O_FETCH_W));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b1, S_MEMADR,  O_MEMADR));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b0, S_MEMWR,   O_MEMWR_W));
        vecs.push_back(mk(6'b101011, 1'b0, 1'b1, S_MEMWR,   O_MEMWR_GO));
        // beq taken
        vecs.push_back(mk(6'b000100, 1'b1, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b000100, 1'b1, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b000100, 1'b1, 1'b1, S_BRANCH,  O_BR_TAKEN));
        // beq not taken
        vecs.push_back(mk(6'b000100, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b000100, 1'b0, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b000100, 1'b0, 1'b1, S_BRANCH,  O_BR_NOT));
        // j
        vecs.push_back(mk(6'b000010, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b000010, 1'b0, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b000010, 1'b0, 1'b1, S_JUMP,    O_JUMP));
        // addi
        vecs.push_back(mk(6'b001000, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b001000, 1'b0, 1'b1, S_DECODE,  O_DECODE));
        vecs.push_back(mk(6'b001000, 1'b0, 1'b1, S_ADDI_EX, O_ADDI_EX));
        vecs.push_back(mk(6'b001000, 1'b0, 1'b1, S_ADDI_WB, O_ADDI_WB));
        // unsupported opcode: 2 cycles, back to fetch
        vecs.push_back(mk(6'b111111, 1'b0, 1'b1, S_FETCH,   O_FETCH_GO));
        vecs.push_back(mk(6'b111111, 1'b0, 1'b1, S_DECODE,  O_DECODE_IL));
        vecs.push_back(mk(6'b111111, 1'b0, 1'b0, S_FETCH,   O_FETCH_W));

        // Reset state, with inputs that would otherwise enable things
        rst = 1'b1; op = OP_LW; zero = 1'b1; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset_state", S_RST);
        check_outs("reset_outs", 17'b0);

        // Release between edges; first edge afterwards enters fetch
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            op        = vecs[i].op;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].mem_ready;
            #2;
            check_state($sformatf("vec%0d_state", i), vecs[i].st);
            check_outs($sformatf("vec%0d_outs", i), vecs[i].outs);
            $display("[TB] vec %0d op=%b zero=%b rdy=%b state=%0d outs=%b",
                     i, vecs[i].op, vecs[i].zero, vecs[i].mem_ready, state, obs);
            @(posedge clk);
            #1;
        end

        // Hand sequence: asynchronous reset in the middle of a stalled lw read
        op = OP_LW; mem_ready = 1'b1; zero = 1'b0;
        @(posedge clk); #1;               // FETCH -> DECODE
        @(posedge clk); #1;               // DECODE -> MEMADR
        mem_ready = 1'b0;
        @(posedge clk); #1;               // MEMADR -> MEMRD
        #2;
        check_state("memrd_before_rst", S_MEMRD);
        check_outs("memrd_outs", O_MEMRD);
        rst = 1'b1;
        #1;
        check_state("async_rst_state", S_RST);
        check_outs("async_rst_outs", 17'b0);
        $display("[TB] async reset mid-read state=%0d outs=%b", state, obs);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_state("after_release", S_RST);
        @(posedge clk); #1;
        check_state("first_edge_fetch", S_FETCH);
        tests++;
        if (MemRead !== 1'b1) begin
            errors++;
            $display("FAIL first_edge_memread: got %b expected 1", MemRead);
        end
        $display("[TB] post-reset state=%0d MemRead=%b", state, MemRead);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
